// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point arithmetic unit.
// Wide intermediates are 64 bits, so DATA_WIDTH is limited to 32.
package fxp_pkg;

    localparam int unsigned DefaultDataWidth = 16;
    localparam int unsigned DefaultFixedPnt  = 8;
    localparam int unsigned WideW            = 64;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef logic signed [WideW-1:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  overflow;
        logic  underflow;
    } sat_t;

    function automatic wide_t fxp_max(input int unsigned width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t fxp_min(input int unsigned width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    function automatic sat_t saturate(input wide_t x, input int unsigned width);
        sat_t s;
        s.value     = x;
        s.overflow  = 1'b0;
        s.underflow = 1'b0;
        if (x > fxp_max(width)) begin
            s.value    = fxp_max(width);
            s.overflow = 1'b1;
        end else if (x < fxp_min(width)) begin
            s.value     = fxp_min(width);
            s.underflow = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/fxp_divider.sv
// Combinational signed fixed-point divider producing an unsaturated wide quotient.
// FXP_ROUND_EN selects round-half-away-from-zero instead of truncation toward zero.
module fxp_divider
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned FIXED_PNT  = DefaultFixedPnt
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output wide_t                 quot_o,
    output logic                  div_by_zero_o
);

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    wide_t                        a_w;
    wide_t                        b_w;
    wide_t                        num;
    wide_t                        q_raw;

    assign a_s = a_i;
    assign b_s = b_i;
    assign a_w = wide_t'(a_s);
    assign b_w = wide_t'(b_s);

    // MIN / -1 needs no special case: the wide numerator keeps the quotient
    // representable and the caller's saturation clips it to MAX.
    always_comb begin
        quot_o        = '0;
        div_by_zero_o = 1'b0;
        q_raw         = '0;
        num           = a_w <<< FIXED_PNT;
        if (b_w == '0) begin
            div_by_zero_o = 1'b1;
            // Just beyond the range so saturation raises the matching flag.
            quot_o = a_w[WideW-1] ? fxp_min(DATA_WIDTH) - wide_t'(1)
                                  : fxp_max(DATA_WIDTH) + wide_t'(1);
        end else begin
`ifdef FXP_ROUND_EN
            // One extra quotient bit; adding it back in magnitude rounds half away.
            q_raw  = (num <<< 1) / b_w;
            quot_o = q_raw[WideW-1] ? -((-q_raw + wide_t'(1)) >>> 1)
                                    : (q_raw + wide_t'(1)) >>> 1;
`else
            q_raw  = num / b_w;
            quot_o = q_raw;
`endif
        end
    end

endmodule

// File: rtl/fxp_arith_unit.sv
// Registered saturating signed Q-format add/sub/mul/div, one op per cycle, latency one.
// Define FXP_ROUND_EN for round-to-nearest (ties away from zero) on mul and div.
module fxp_arith_unit
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned FIXED_PNT  = DefaultFixedPnt
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  div_by_zero
);

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    wide_t                        a_w;
    wide_t                        b_w;
    wide_t                        prod;
    wide_t                        prod_adj;
    wide_t                        quot;
    wide_t                        wide_val;
    logic                         div_zero;
    sat_t                         sat;
    logic                         unused_sat;

    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  overflow_d, overflow_q;
    logic                  underflow_d, underflow_q;
    logic                  div_by_zero_d, div_by_zero_q;
    logic                  out_valid_d, out_valid_q;

    assign a_s = a;
    assign b_s = b;
    assign a_w = wide_t'(a_s);
    assign b_w = wide_t'(b_s);

    fxp_divider #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIXED_PNT  (FIXED_PNT)
    ) u_divider (
        .a_i           (a),
        .b_i           (b),
        .quot_o        (quot),
        .div_by_zero_o (div_zero)
    );

    always_comb begin
        prod = a_w * b_w;
`ifdef FXP_ROUND_EN
        // Negative products get half minus one so the floor shift rounds ties away.
        prod_adj = prod + (prod[WideW-1] ? (wide_t'(1) <<< (FIXED_PNT - 1)) - wide_t'(1)
                                         : (wide_t'(1) <<< (FIXED_PNT - 1)));
`else
        prod_adj = prod;
`endif
    end

    always_comb begin
        wide_val      = '0;
        div_by_zero_d = 1'b0;
        unique case (op_e'(op))
            OP_ADD: wide_val = a_w + b_w;
            OP_SUB: wide_val = a_w - b_w;
            OP_MUL: wide_val = prod_adj >>> FIXED_PNT;
            OP_DIV: begin
                wide_val      = quot;
                div_by_zero_d = div_zero;
            end
            default: wide_val = '0;
        endcase
        sat = saturate(wide_val, DATA_WIDTH);

        out_valid_d = in_valid;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (in_valid) begin
            result_d    = sat.value[DATA_WIDTH-1:0];
            overflow_d  = sat.overflow;
            underflow_d = sat.underflow;
        end else begin
            div_by_zero_d = div_by_zero_q;
        end
    end

    assign unused_sat = ^sat.value[WideW-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q      <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            result_q      <= result_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            div_by_zero_q <= div_by_zero_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign result      = result_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign div_by_zero = div_by_zero_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fxp_arith_unit.sv
// Scoreboard bench for fxp_arith_unit at the default Q7.8 configuration.
module tb_fxp_arith_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fxp_arith_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t   e;
        longint sa = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint v  = 0;
        longint p, num, q, r;
        e.dbz = 1'b0;
        case (o)
            2'd0: v = sa + sy;
            2'd1: v = sa - sy;
            2'd2: begin
                p = sa * sy;
`ifdef FXP_ROUND_EN
                v = (p >= 0) ? ((p + 128) >>> 8) : -(((-p) + 128) >>> 8);
`else
                v = p >>> 8;
`endif
            end
            default: begin
                if (sy == 0) begin
                    e.dbz = 1'b1;
                    v = (sa >= 0) ? 40000 : -40000;
                end else begin
                    num = sa * 256;
                    q   = num / sy;
`ifdef FXP_ROUND_EN
                    r = num % sy;
                    if (2 * labs(r) >= labs(sy))
                        q = q + (((num < 0) != (sy < 0)) ? -1 : 1);
`endif
                    v = q;
                end
            end
        endcase
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (v > 32767) begin
            v = 32767;
            e.ovf = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            e.unf = 1'b1;
        end
        e.res = v[15:0];
        return e;
    endfunction

    task automatic drive(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        sb.push_back(model(o, x, y));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: every out_valid pulse pops and compares one expected result.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("result", 32'(result), 32'(e.res));
                check_eq("overflow", 32'(overflow), 32'(e.ovf));
                check_eq("underflow", 32'(underflow), 32'(e.unf));
                check_eq("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pick_operand();
        logic [15:0] special [7];
        special[0] = 16'h0000;
        special[1] = 16'h0001;
        special[2] = 16'h7FFF;
        special[3] = 16'h8000;
        special[4] = 16'hFFFF;
        special[5] = 16'h0100;
        special[6] = 16'hFF00;
        if ($urandom_range(0, 2) == 0) return special[$urandom_range(0, 6)];
        return 16'($urandom);
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 2'd0;
        a        = '0;
        b        = '0;
        #3;
        check_eq("reset_result", 32'(result), 32'd0);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_flags", 32'({overflow, underflow, div_by_zero}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add, then the hold cycle.
        drive(2'd0, 16'h0180, 16'h0200);
        idle();
        @(posedge clk);
        #1;
        check_eq("hold_valid", 32'(out_valid), 32'd0);
        check_eq("hold_result", 32'(result), 32'h0380);

        drive(2'd2, 16'hFF00, 16'h0180);
        drive(2'd2, 16'h0001, 16'h0080);
        drive(2'd3, 16'h0300, 16'h0200);
        drive(2'd3, 16'h0100, 16'h0000);
        drive(2'd3, 16'hFF00, 16'h0000);
        drive(2'd0, 16'h7000, 16'h2000);
        drive(2'd1, 16'h8000, 16'h0100);
        drive(2'd2, 16'h4000, 16'h0400);
        drive(2'd1, 16'h0000, 16'h8000);
        drive(2'd3, 16'h8000, 16'hFF00);
        idle();

        // Back-to-back add, mul, div.
        drive(2'd0, 16'h0180, 16'h0200);
        drive(2'd2, 16'hFF00, 16'h0180);
        drive(2'd3, 16'h0300, 16'h0200);
        idle();
        idle();

        // Reset while an op is being presented: it must be discarded.
        drive(2'd0, 16'h0100, 16'h0100);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'd0;
        a        = 16'h1234;
        b        = 16'h0001;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_result", 32'(result), 32'd0);
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_flags", 32'({overflow, underflow, div_by_zero}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'd1, 16'h0500, 16'h0200);
        idle();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else drive(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
        end
        idle();

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fxp_arith_unit.md
Name: fxp_arith_unit

Overview:
Registered, signed fixed-point arithmetic unit. Supports add, subtract, multiply and divide on two-operand Q-format numbers, and saturates every result. It is the shared arithmetic engine used by function-evaluation blocks such as the exp/Taylor-series datapath. One operation is accepted per cycle, and the result appears one cycle later.

Parameters:
DATA_WIDTH, 16, total operand/result width, two's complement
FIXED_PNT, 8, number of fractional bits; the format is Q(DATA_WIDTH-FIXED_PNT-1).FIXED_PNT

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands/op valid this cycle
op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div
a  input  DATA_WIDTH  signed operand 1 (num1)
b  input  DATA_WIDTH  signed operand 2 (num2)
out_valid  output  1  result valid, single-cycle pulse per accepted op
result  output  DATA_WIDTH  signed saturated result
overflow  output  1  result clipped to positive max
underflow  output  1  result clipped to negative min
div_by_zero  output  1  div op with b == 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: result = 0, overflow = 0, underflow = 0, div_by_zero = 0, out_valid = 0. Asserting rst_n low mid-operation discards the in-flight op.
- Latency:
  - If in_valid is sampled high at edge N, then result, flags and out_valid=1 are valid after edge N.
  - out_valid drops on the next edge unless in_valid is high again.
  - Back-to-back ops are accepted every cycle; there is no backpressure.
- When in_valid is low: result and flags hold their last values; out_valid = 0.
- Constants: MAX = 2^(DATA_WIDTH-1)-1 (0x7FFF); MIN = -2^(DATA_WIDTH-1) (0x8000).
- Saturation and flags:
  - Every op computes in extended width, then saturates.
  - Value > MAX gives MAX with overflow=1; value < MIN gives MIN with underflow=1.
  - The flags are otherwise 0 and are mutually exclusive.
- add: a + b computed in DATA_WIDTH+1 bits.
- sub: a - b computed in DATA_WIDTH+1 bits. a=0, b=MIN yields MAX with overflow.
- mul: 2*DATA_WIDTH-bit signed product, arithmetic right shift by FIXED_PNT (truncation toward -inf), then saturate.
- div:
  - Quotient = (a sign-extended and shifted left by FIXED_PNT) / b, signed, truncating toward zero, then saturate.
  - MIN / -1 (in integer terms) saturates to MAX with overflow.
  - b == 0: div_by_zero=1; result is MAX if a >= 0, else MIN. overflow/underflow are set to match the clipped value.
- div_by_zero is 0 for every non-div op.
- All arithmetic is combinational between the input and output registers. There are no multicycle paths.

Optional Feature:
Macro FXP_ROUND_EN.
- Defined: mul and div round to nearest, with ties away from zero.
  - mul adds sign-corrected 2^(FIXED_PNT-1) before the shift.
  - div computes one extra quotient bit and rounds on it.
  - Rounding happens before saturation.
- Undefined: truncation exactly as described under Behaviour.
- add and sub are unaffected either way.

Decomposition:
- Package fxp_pkg holds:
  - the op enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - default DATA_WIDTH and FIXED_PNT;
  - MAX/MIN localparams as functions of width;
  - a saturate function taking a wide signed value and returning the clipped value plus overflow/underflow.
- One sub-module is natural: fxp_divider, the combinational signed divider with zero/MIN/-1 handling. It is instantiated once.
- add, sub and mul stay inline in the top.

Test Plan:
- add 0x0180 (1.5) + 0x0200 (2.0), in_valid for one cycle -> next cycle out_valid=1, result=0x0380, all flags 0; following cycle out_valid=0, result holds 0x0380.
- mul 0xFF00 (-1.0) x 0x0180 -> 0xFE80 (-1.5); mul 0x0001 x 0x0080 -> 0x0000 without FXP_ROUND_EN, 0x0001 with it.
- div 0x0300 / 0x0200 -> 0x0180; div 0x0100 / 0x0000 -> 0x7FFF with div_by_zero=1 and overflow=1; div 0xFF00 / 0x0000 -> 0x8000 with div_by_zero=1 and underflow=1.
- Saturation: add 0x7000 + 0x2000 -> 0x7FFF with overflow=1; sub 0x8000 - 0x0100 -> 0x8000 with underflow=1; mul 0x4000 x 0x0400 -> 0x7FFF with overflow=1.
- Back-to-back ops on 3 consecutive cycles (add, mul, div above) -> 3 consecutive out_valid cycles with results in order.
- Assert rst_n low while in_valid=1 mid-stream -> outputs immediately 0, out_valid=0; the first op after release is accepted normally.
